// File: rtl/fft8_out_serializer_if.sv
// Frame-in / beat-out handshake bundle for the FFT output serializer.
// master = upstream producer plus downstream consumer, slave = serializer.
interface fft8_out_serializer_if #(
  parameter int W     = 16,
  parameter int N_PTS = 8
);
  localparam int IDX_W = $clog2(N_PTS);

  logic               in_valid;
  logic               in_ready;
  logic [N_PTS*W-1:0] in_real;
  logic [N_PTS*W-1:0] in_imag;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_real;
  logic [W-1:0]       out_imag;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag,
    input  out_idx, out_last
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag,
    output out_idx, out_last
  );
endinterface

// File: rtl/fft8_out_serializer.sv
// Captures one FFT frame in parallel and streams bins out in index order.
// Define FFT_OUT_SCALE_EN to apply 1/N (>>> IDX_W) normalisation on output.
module fft8_out_serializer #(
  parameter int W     = 16,
  parameter int N_PTS = 8
) (
  input logic                  clk,
  input logic                  rst,
  fft8_out_serializer_if.slave bus
);
  localparam int IDX_W = $clog2(N_PTS);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                state;
  logic                  out_valid_q;
  logic [IDX_W-1:0]      idx;
  logic signed [W-1:0]   buf_re [N_PTS];
  logic signed [W-1:0]   buf_im [N_PTS];
  logic                  last_beat;
  logic                  beat_acc;
  logic                  take;

  assign last_beat = (idx == IDX_W'(N_PTS - 1));
  assign beat_acc  = out_valid_q & bus.out_ready;
  assign take      = bus.in_valid & bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_valid_q & last_beat;
  assign bus.out_idx   = idx;
  assign bus.in_ready  = (state == IDLE) |
                         ((state == STREAM) & bus.out_last & bus.out_ready);

`ifdef FFT_OUT_SCALE_EN
  assign bus.out_real = W'(buf_re[idx] >>> IDX_W);
  assign bus.out_imag = W'(buf_im[idx] >>> IDX_W);
`else
  assign bus.out_real = buf_re[idx];
  assign bus.out_imag = buf_im[idx];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      idx         <= '0;
      for (int k = 0; k < N_PTS; k++) begin
        buf_re[k] <= '0;
        buf_im[k] <= '0;
      end
    end else begin
      if (take) begin
        for (int k = 0; k < N_PTS; k++) begin
          buf_re[k] <= bus.in_real[k*W +: W];
          buf_im[k] <= bus.in_imag[k*W +: W];
        end
      end
      unique case (state)
        IDLE: begin
          if (take) begin
            state       <= STREAM;
            out_valid_q <= 1'b1;
            idx         <= '0;
          end
        end
        STREAM: begin
          if (beat_acc) begin
            if (!last_beat) begin
              idx <= idx + IDX_W'(1);
            end else if (take) begin
              idx <= '0;
            end else begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
              idx         <= '0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          idx         <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft8_out_serializer.sv
// Directed checks for fft8_out_serializer: reset, streaming,
// backpressure, back-to-back frames, ignored input, scaling.
module tb_fft8_out_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fft8_out_serializer_if #(.W(16), .N_PTS(8)) bus ();

  fft8_out_serializer #(.W(16), .N_PTS(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [2:0]  idx;
    logic        last;
  } vec_t;

  vec_t        vec [8];
  logic [15:0] fr_re [8];
  logic [15:0] fr_im [8];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] sc(logic [15:0] v);
`ifdef FFT_OUT_SCALE_EN
    return 16'($signed(v) >>> 3);
`else
    return v;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bus();
    for (int k = 0; k < 8; k++) begin
      bus.in_real[k*16 +: 16] = fr_re[k];
      bus.in_imag[k*16 +: 16] = fr_im[k];
    end
  endtask

  task automatic set_frame(int base_re, int base_im, int sgn);
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = 16'(base_re + k);
      fr_im[k] = 16'(sgn * (base_im + k));
    end
  endtask

  task automatic send_frame();
    int n;
    n = 0;
    load_bus();
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_beat(string tag, int k, logic [15:0] re,
                          logic [15:0] im, logic last);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_idx"}, 32'(bus.out_idx), 32'(k));
    chk({tag, "_real"}, 32'(bus.out_real), 32'(re));
    chk({tag, "_imag"}, 32'(bus.out_imag), 32'(im));
    chk({tag, "_last"}, 32'(bus.out_last), 32'(last));
  endtask

  task automatic chk_vec(string tag, int k);
    chk_beat(tag, k, sc(vec[k].re), sc(vec[k].im), vec[k].last);
  endtask

  initial begin
    int got;
    int c;
    logic pat;

    vec[0] = '{16'd1, 16'hFFFF, 3'd0, 1'b0};
    vec[1] = '{16'd2, 16'hFFFE, 3'd1, 1'b0};
    vec[2] = '{16'd3, 16'hFFFD, 3'd2, 1'b0};
    vec[3] = '{16'd4, 16'hFFFC, 3'd3, 1'b0};
    vec[4] = '{16'd5, 16'hFFFB, 3'd4, 1'b0};
    vec[5] = '{16'd6, 16'hFFFA, 3'd5, 1'b0};
    vec[6] = '{16'd7, 16'hFFF9, 3'd6, 1'b0};
    vec[7] = '{16'd8, 16'hFFF8, 3'd7, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;

    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_real", 32'(bus.out_real), 32'd0);
    chk("rst_imag", 32'(bus.out_imag), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // reset mid-stream at idx 3
    set_frame(1, 1, -1);
    bus.out_ready = 1'b1;
    send_frame();
    tick(); tick(); tick();
    chk("mid_idx", 32'(bus.out_idx), 32'd3);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_idx", 32'(bus.out_idx), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_real", 32'(bus.out_real), 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
    end

    // single frame, consumer always ready
    set_frame(1, 1, -1);
    bus.out_ready = 1'b1;
    send_frame();
    for (int k = 0; k < 8; k++) begin
      chk_vec("single", k);
      tick();
    end
    chk("single_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("single_idle_ready", 32'(bus.in_ready), 32'd1);

    // backpressure 1,0,0 pattern
    bus.out_ready = 1'b0;
    send_frame();
    got = 0;
    c = 0;
    while (got < 8 && c < 40) begin
      pat = (c % 3 == 0);
      bus.out_ready = pat;
      #1;
      chk_vec("bp", got);
      tick();
      if (pat) got++;
      c++;
    end
    chk("bp_done_idle", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;

    // back-to-back: frame B waits during A
    set_frame(1, 1, -1);
    send_frame();
    set_frame(100, 0, 1);
    load_bus();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_in_ready", 32'(bus.in_ready), 32'(k == 7));
      chk_vec("b2b_a", k);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_beat("b2b_b", k, sc(16'(100 + k)), sc(16'(k)), k == 7);
      tick();
    end
    chk("b2b_idle", 32'(bus.out_valid), 32'd0);

    // ignored input at idx 4
    set_frame(1, 1, -1);
    send_frame();
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        set_frame(500, 500, 1);
        load_bus();
        bus.in_valid = 1'b1;
        #1;
        chk("ign_in_ready", 32'(bus.in_ready), 32'd0);
      end else begin
        bus.in_valid = 1'b0;
      end
      chk_vec("ign", k);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("ign_idle", 32'(bus.out_valid), 32'd0);

    // scaling corner on bin 0
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = '0;
      fr_im[k] = '0;
    end
    fr_re[0] = 16'h7FF8;
    fr_im[0] = 16'hFFF7;
    send_frame();
`ifdef FFT_OUT_SCALE_EN
    chk("scale_real", 32'(bus.out_real), 32'h0FFF);
    chk("scale_imag", 32'(bus.out_imag), 32'hFFFE);
`else
    chk("raw_real", 32'(bus.out_real), 32'h7FF8);
    chk("raw_imag", 32'(bus.out_imag), 32'hFFF7);
`endif
    for (int k = 0; k < 8; k++) tick();
    chk("scale_idle", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
